axis_stream_fifo: RTL and testbench
===================================

Name: axis_stream_fifo

Overview:
- Parametrised synchronous AXI4-Stream FIFO with full tready backpressure on both sides.
- Carries tdata, tlast and a multi-bit tuser.
- Optional packet (store-and-forward) mode: no beat of a frame is presented downstream until its tlast beat is stored.
- Sits between stream producers and consumers in the video/stream datapath to absorb rate mismatch and decouple backpressure.

Parameters:
- DATA_WIDTH, 8, tdata width in bits (>=1).
- USER_WIDTH, 1, tuser width in bits (>=1).
- DEPTH, 16, storage entries; power of two, >=2.
- PACKET_MODE, 0, 0 = cut-through, 1 = store-and-forward per frame.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- s_tdata  input  DATA_WIDTH  slave data.
- s_tuser  input  USER_WIDTH  slave sideband (e.g. start-of-frame).
- s_tlast  input  1  slave end-of-frame.
- s_tvalid  input  1  slave valid.
- s_tready  output  1  slave ready.
- m_tdata  output  DATA_WIDTH  master data.
- m_tuser  output  USER_WIDTH  master sideband.
- m_tlast  output  1  master end-of-frame.
- m_tvalid  output  1  master valid.
- m_tready  input  1  master ready.
- count  output  $clog2(DEPTH+1)  stored beats, 0..DEPTH.
- frames  output  $clog2(DEPTH+1)  complete frames stored (tlast beats in FIFO).

Behaviour:
- Reset:
  - While rst=1: s_tready=0, m_tvalid=0, count=0, frames=0, read/write pointers=0.
  - On the first cycle after rst falls, s_tready=1.
  - m_tdata, m_tuser and m_tlast are only meaningful when m_tvalid=1; they have no reset value and the bench must not check them otherwise.
  - Reset mid-frame discards all stored beats, including partial frames. There is no flush handshake.
- Write: beat accepted when s_tvalid && s_tready at a rising edge. The beat is written to mem[wr_ptr] and wr_ptr increments modulo DEPTH.
- Read: beat consumed when m_tvalid && m_tready. rd_ptr increments modulo DEPTH.
- s_tready = !rst && (count < DEPTH). It is registered-state derived, with no combinational path from m_tready.
- A simultaneous write and read at count==DEPTH is not possible, since s_tready=0. When full, a read frees a slot; s_tready rises the following cycle.
- Simultaneous write and read at 0<count<DEPTH: count unchanged, both pointers advance.
- count: +1 on write-only, -1 on read-only, unchanged otherwise.
- frames: +1 on a write with s_tlast=1, -1 on a read with m_tlast=1. Both together leave it unchanged.
- Output is first-word-fall-through:
  - m_tdata/m_tuser/m_tlast = mem[rd_ptr].
  - A beat written at edge N is visible with m_tvalid=1 in the cycle after edge N, i.e. 1-cycle latency when empty.
- Cut-through (PACKET_MODE=0): m_tvalid = (count != 0).
- Store-and-forward (PACKET_MODE=1): m_tvalid = (count != 0) && ((frames != 0) || (count == DEPTH)).
  - The count==DEPTH term is a defined deadlock escape for frames longer than DEPTH: such a frame streams out cut-through until its tlast is stored.
  - Once m_tvalid asserts for a frame it stays asserted until that frame's tlast is read or the FIFO empties. No beat is withdrawn while m_tready=0 (AXIS stability rule).
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. Full/empty are decided by count, not by pointer comparison.
- m_tvalid must not depend combinationally on m_tready.

Decomposition:
- Package axis_pkg holds:
  - localparam function for count width, clog2(DEPTH+1);
  - typedef struct packed {data, user, last} axis_beat_t parameterised via macro, or packed concatenation of width DATA_WIDTH+USER_WIDTH+1.
- One sub-module, axis_fifo_ram: simple dual-port memory with synchronous write and asynchronous read, DEPTH x (DATA_WIDTH+USER_WIDTH+1).
- Control logic (pointers, count, frames, valid/ready) lives in axis_stream_fifo.

Test Plan:
- Reset/idle: hold rst 3 cycles -> s_tready=0, m_tvalid=0, count=0. Release -> s_tready=1 next cycle.
- Cut-through fill/drain: DEPTH=16, m_tready=0, push 16 beats 0x00..0x0F -> count=16, s_tready=0. Assert m_tready -> 0x00..0x0F in order, one per cycle, s_tready=1 after first read.
- Simultaneous R/W: count=5, s_tvalid=m_tready=1 for 20 cycles with random data -> count stays 5, output order matches input, pointers wrap past 15 correctly.
- Packet mode: PACKET_MODE=1, push 4-beat frame with tlast on beat 4 and m_tready=1 -> m_tvalid=0 until the cycle after beat 4 is written, then 4 consecutive beats, tuser/tlast preserved, frames 1->0.
- Oversize frame: PACKET_MODE=1, DEPTH=16, 20-beat frame, m_tready=1 -> at count=16 m_tvalid=1, all 20 beats delivered in order, no deadlock.
- Reset mid-operation: 7 beats stored, partial frame, assert rst 1 cycle -> count=0, frames=0, m_tvalid=0. A new frame afterwards is delivered intact with no stale beats.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared helpers for the AXI4-Stream FIFO: width functions for the
// occupancy counters, pointers and the packed beat word stored in RAM.
package axis_pkg;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Address width for a power-of-two depth (at least one bit).
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Stored beat is {tdata, tuser, tlast}.
    function automatic int beat_w(input int dw, input int uw);
        return dw + uw + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Ports: clk_i, wr_en_i/wr_addr_i/wr_data_i (write), rd_addr_i/rd_data_o (read).
module axis_fifo_ram
    import axis_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16
) (
    input  logic                      clk_i,
    input  logic                      wr_en_i,
    input  logic [ptr_w(DEPTH)-1:0]   wr_addr_i,
    input  logic [WIDTH-1:0]          wr_data_i,
    input  logic [ptr_w(DEPTH)-1:0]   rd_addr_i,
    output logic [WIDTH-1:0]          rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/axis_stream_fifo.sv
// Synchronous AXI4-Stream FIFO, first-word-fall-through, optional
// store-and-forward per frame.
// Ports: clk, rst (sync, active high); s_* slave stream in; m_* master
// stream out; count = stored beats; frames = stored tlast beats.
module axis_stream_fifo
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int USER_WIDTH  = 1,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       s_tdata,
    input  logic [USER_WIDTH-1:0]       s_tuser,
    input  logic                        s_tlast,
    input  logic                        s_tvalid,
    output logic                        s_tready,
    output logic [DATA_WIDTH-1:0]       m_tdata,
    output logic [USER_WIDTH-1:0]       m_tuser,
    output logic                        m_tlast,
    output logic                        m_tvalid,
    input  logic                        m_tready,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic [$clog2(DEPTH+1)-1:0]  frames
);

    localparam int  CW  = cnt_w(DEPTH);
    localparam int  AW  = ptr_w(DEPTH);
    localparam int  BW  = beat_w(DATA_WIDTH, USER_WIDTH);
    localparam bit  PKT = (PACKET_MODE != 0);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] frames_q, frames_d;
    logic          drain_q, drain_d;

    logic          wr_en;
    logic          rd_en;
    logic          full;
    logic          empty;
    logic          release_ok;
    logic [BW-1:0] wr_beat;
    logic [BW-1:0] rd_beat;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    assign s_tready = !rst && !full;

    // In packet mode a beat is released once a whole frame is stored,
    // or when the FIFO is full (a frame longer than DEPTH would
    // otherwise deadlock). drain_q holds release for the rest of such
    // a frame so no beat is withdrawn once offered.
    assign release_ok = !PKT || (frames_q != '0) || full || drain_q;
    assign m_tvalid   = !rst && !empty && release_ok;

    assign wr_en = s_tvalid && s_tready;
    assign rd_en = m_tvalid && m_tready;

    assign wr_beat = {s_tdata, s_tuser, s_tlast};

    axis_fifo_ram #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i     (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_beat),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_beat)
    );

    assign m_tdata = rd_beat[BW-1 -: DATA_WIDTH];
    assign m_tuser = rd_beat[USER_WIDTH:1];
    assign m_tlast = rd_beat[0];

    assign count  = count_q;
    assign frames = frames_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        frames_d = frames_q;
        drain_d  = drain_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (wr_en && !rd_en) begin
            count_d = count_q + CW'(1);
        end else if (!wr_en && rd_en) begin
            count_d = count_q - CW'(1);
        end

        if ((wr_en && s_tlast) && !(rd_en && m_tlast)) begin
            frames_d = frames_q + CW'(1);
        end else if (!(wr_en && s_tlast) && (rd_en && m_tlast)) begin
            frames_d = frames_q - CW'(1);
        end

        if (PKT && full && (frames_q == '0)) begin
            drain_d = 1'b1;
        end
        if (rd_en && m_tlast) begin
            drain_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            frames_q <= '0;
            drain_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            frames_q <= frames_d;
            drain_q  <= drain_d;
        end
    end

endmodule

// File: tb/tb_axis_stream_fifo.sv
// Scoreboard bench for axis_stream_fifo: one cut-through and one
// store-and-forward instance, checked against a queue-based model.
module tb_axis_stream_fifo;

    localparam int DW = 8;
    localparam int UW = 2;
    localparam int D  = 16;

    logic clk = 1'b0;
    logic rst;

    logic [DW-1:0] s_tdata  [2];
    logic [UW-1:0] s_tuser  [2];
    logic          s_tlast  [2];
    logic          s_tvalid [2];
    logic          s_tready [2];
    logic [DW-1:0] m_tdata  [2];
    logic [UW-1:0] m_tuser  [2];
    logic          m_tlast  [2];
    logic          m_tvalid [2];
    logic          m_tready [2];
    logic [4:0]    count    [2];
    logic [4:0]    frames   [2];

    int n_cmp  = 0;
    int n_fail = 0;
    bit done;

    always #5 clk = ~clk;

    axis_stream_fifo #(
        .DATA_WIDTH (DW), .USER_WIDTH (UW),
        .DEPTH (D), .PACKET_MODE (0)
    ) dut0 (
        .clk (clk), .rst (rst),
        .s_tdata (s_tdata[0]), .s_tuser (s_tuser[0]),
        .s_tlast (s_tlast[0]), .s_tvalid (s_tvalid[0]),
        .s_tready (s_tready[0]),
        .m_tdata (m_tdata[0]), .m_tuser (m_tuser[0]),
        .m_tlast (m_tlast[0]), .m_tvalid (m_tvalid[0]),
        .m_tready (m_tready[0]),
        .count (count[0]), .frames (frames[0])
    );

    axis_stream_fifo #(
        .DATA_WIDTH (DW), .USER_WIDTH (UW),
        .DEPTH (D), .PACKET_MODE (1)
    ) dut1 (
        .clk (clk), .rst (rst),
        .s_tdata (s_tdata[1]), .s_tuser (s_tuser[1]),
        .s_tlast (s_tlast[1]), .s_tvalid (s_tvalid[1]),
        .s_tready (s_tready[1]),
        .m_tdata (m_tdata[1]), .m_tuser (m_tuser[1]),
        .m_tlast (m_tlast[1]), .m_tvalid (m_tvalid[1]),
        .m_tready (m_tready[1]),
        .count (count[1]), .frames (frames[1])
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of accepted beats per instance. The
    // FIFO state and its valid rule are derived from queue contents.
    for (genvar g = 0; g < 2; g++) begin : mon
        logic [DW+UW:0] q[$];
        bit             streaming;
        int             nl;
        logic           exp_v;
        logic [DW+UW:0] b;

        always @(negedge clk) begin
            if (rst) begin
                chk($sformatf("rst_sready%0d", g), 32'(s_tready[g]), 0);
                chk($sformatf("rst_mvalid%0d", g), 32'(m_tvalid[g]), 0);
                q.delete();
                streaming = 1'b0;
            end else begin
                nl = 0;
                foreach (q[k]) nl += int'(q[k][0]);
                if (g == 0) exp_v = (q.size() != 0);
                else exp_v = (q.size() != 0) &&
                             (nl != 0 || q.size() == D || streaming);
                chk($sformatf("count%0d", g), 32'(count[g]), q.size());
                chk($sformatf("frames%0d", g), 32'(frames[g]), nl);
                chk($sformatf("sready%0d", g), 32'(s_tready[g]),
                    32'(q.size() < D));
                chk($sformatf("mvalid%0d", g), 32'(m_tvalid[g]),
                    32'(exp_v));
                if (m_tvalid[g] && m_tready[g]) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL underflow%0d: got beat, expected none",
                                 g);
                    end else begin
                        b = q.pop_front();
                        chk($sformatf("beat%0d", g),
                            32'({m_tdata[g], m_tuser[g], m_tlast[g]}),
                            32'(b));
                        streaming = !m_tlast[g];
                    end
                end
                if (s_tvalid[g] && s_tready[g])
                    q.push_back({s_tdata[g], s_tuser[g], s_tlast[g]});
            end
        end
    end

    function automatic int qsize(input int sel);
        return (sel == 0) ? mon[0].q.size() : mon[1].q.size();
    endfunction

    // Called and returns #1 after a rising edge.
    task automatic send(input int sel, input logic [DW-1:0] d,
                        input logic [UW-1:0] u, input logic l,
                        input int gap);
        bit hs;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_tdata[sel]  = d;
        s_tuser[sel]  = u;
        s_tlast[sel]  = l;
        s_tvalid[sel] = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            hs = s_tready[sel];
            @(posedge clk);
            #1;
            if (hs) break;
            if (t > 300) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_timeout%0d: got no ready, expected ready",
                         sel);
                break;
            end
        end
        s_tvalid[sel] = 1'b0;
    endtask

    task automatic wait_empty(input int sel);
        bit ok = 1'b0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (qsize(sel) == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout%0d: got %0d left, expected 0",
                     sel, qsize(sel));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic producer(input int sel, input int nfr);
        int len;
        for (int f = 0; f < nfr; f++) begin
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++)
                send(sel, DW'($urandom), UW'($urandom), (k == len - 1),
                     $urandom_range(0, 2));
        end
    endtask

    task automatic toggler();
        while (1) begin
            @(posedge clk);
            #1;
            if (done) break;
            m_tready[0] = ($urandom_range(0, 3) != 0);
            m_tready[1] = ($urandom_range(0, 2) != 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_tdata[i]  = '0;
            s_tuser[i]  = '0;
            s_tlast[i]  = 1'b0;
            s_tvalid[i] = 1'b0;
            m_tready[i] = 1'b0;
        end

        repeat (3) begin
            @(negedge clk);
            chk("reset_count0", 32'(count[0]), 0);
            chk("reset_count1", 32'(count[1]), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("release_sready0", 32'(s_tready[0]), 1);
        chk("release_sready1", 32'(s_tready[1]), 1);
        @(posedge clk);
        #1;

        // Cut-through fill then drain.
        for (int i = 0; i < D; i++)
            send(0, DW'(i), UW'(i), (i % 4 == 3), 0);
        @(negedge clk);
        chk("full_count", 32'(count[0]), D);
        chk("full_sready", 32'(s_tready[0]), 0);
        @(posedge clk);
        #1;
        m_tready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("sready_after_read", 32'(s_tready[0]), 1);
        wait_empty(0);

        // Steady simultaneous read and write at count 5.
        m_tready[0] = 1'b0;
        for (int i = 0; i < 5; i++)
            send(0, DW'($urandom), UW'($urandom), 1'b0, 0);
        m_tready[0] = 1'b1;
        fork
            for (int i = 0; i < 20; i++)
                send(0, DW'($urandom), UW'($urandom), 1'($urandom), 0);
            repeat (20) begin
                @(negedge clk);
                chk("rw_count", 32'(count[0]), 5);
            end
        join
        wait_empty(0);

        // Store-and-forward: 4-beat frame.
        m_tready[1] = 1'b1;
        for (int i = 0; i < 3; i++)
            send(1, DW'(8'hA0 + i), UW'(i), 1'b0, 0);
        @(negedge clk);
        chk("pkt_hold", 32'(m_tvalid[1]), 0);
        @(posedge clk);
        #1;
        send(1, 8'hA3, 2'd3, 1'b1, 0);
        @(negedge clk);
        chk("pkt_release", 32'(m_tvalid[1]), 1);
        chk("pkt_frames1", 32'(frames[1]), 1);
        wait_empty(1);
        @(negedge clk);
        chk("pkt_frames0", 32'(frames[1]), 0);
        @(posedge clk);
        #1;

        // Oversize frame escapes through the full condition.
        fork
            for (int i = 0; i < 20; i++)
                send(1, DW'(8'h40 + i), UW'($urandom), (i == 19), 0);
            begin
                bit seen = 1'b0;
                for (int t = 0; t < 100; t++) begin
                    @(negedge clk);
                    if (count[1] == 5'(D)) begin
                        seen = 1'b1;
                        break;
                    end
                end
                chk("ovs_reached_full", 32'(seen), 1);
                chk("ovs_full_valid", 32'(m_tvalid[1]), 1);
            end
        join
        wait_empty(1);

        // Random traffic on both instances with random backpressure.
        done = 1'b0;
        fork
            toggler();
        join_none
        fork
            producer(0, 40);
            producer(1, 40);
        join
        done = 1'b1;
        @(posedge clk);
        #1;
        m_tready[0] = 1'b1;
        m_tready[1] = 1'b1;
        wait_empty(0);
        wait_empty(1);

        // Reset with a partial frame stored.
        m_tready[1] = 1'b0;
        for (int i = 0; i < 7; i++)
            send(1, DW'(8'h70 + i), UW'(i), 1'b0, 0);
        @(negedge clk);
        chk("mid_count7", 32'(count[1]), 7);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_count0", 32'(count[1]), 0);
        chk("mid_frames0", 32'(frames[1]), 0);
        chk("mid_mvalid0", 32'(m_tvalid[1]), 0);
        @(posedge clk);
        #1;
        m_tready[1] = 1'b1;
        for (int i = 0; i < 3; i++)
            send(1, DW'(8'hC0 + i), UW'(i), (i == 2), 0);
        wait_empty(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
